// File: rtl/elevator_ctrl_nfloor.sv
// N-floor collective-scheduling elevator controller with latched hall/car requests and travel/door timers.
// Optional feature macro: DOOR_REOPEN_EN (a request at the open floor restarts the door timer).
module elevator_ctrl_nfloor #(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 200000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               start_stop,
  input  logic [FLOORS-1:0]  hall_up,
  input  logic [FLOORS-1:0]  hall_down,
  input  logic [FLOORS-1:0]  car_call,
  output logic [FLOOR_W-1:0] floor,
  output logic [1:0]         state,
  output logic               dir_up,
  output logic [FLOORS-1:0]  pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DOOR = 2'd3
  } state_t;

  localparam logic [31:0]       TRAVEL_LAST    = 32'(TRAVEL_CYCLES - 1);
  localparam logic [31:0]       DOOR_LAST      = 32'(DOOR_CYCLES - 1);
  localparam logic [FLOORS-1:0] HALL_UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] HALL_DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, step_floor;
  logic                dir_q, dir_d;
  logic [FLOORS-1:0]   pending_q, pending_d;
  logic [FLOORS-1:0]   new_raw, new_req, here, clr;
  logic [31:0]         timer_q, timer_d;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    onehot    = '0;
    onehot[f] = 1'b1;
  endfunction

  // True when any bit of p lies strictly above (up=1) or below (up=0) floor f.
  function automatic logic any_beyond(input logic [FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0] f,
                                      input logic up);
    any_beyond = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) any_beyond = 1'b1;
    end
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    clr        = '0;
    here       = onehot(floor_q);
    step_floor = (state_q == S_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    new_raw    = car_call | (hall_up & HALL_UP_MASK) | (hall_down & HALL_DOWN_MASK);
    new_req    = (state_q == S_DOOR) ? (new_raw & ~here) : new_raw;

    if (start_stop) begin
      unique case (state_q)
        S_IDLE: begin
          timer_d = '0;
          if (pending_q[floor_q]) begin
            state_d = S_DOOR;
            clr     = here;
          end else if (any_beyond(pending_q, floor_q, dir_q)) begin
            state_d = dir_q ? S_UP : S_DOWN;
          end else if (any_beyond(pending_q, floor_q, !dir_q)) begin
            state_d = dir_q ? S_DOWN : S_UP;
            dir_d   = !dir_q;
          end
        end
        S_UP, S_DOWN: begin
          if (timer_q == TRAVEL_LAST) begin
            timer_d = '0;
            floor_d = step_floor;
            if (pending_q[step_floor]) begin
              state_d = S_DOOR;
              clr     = onehot(step_floor);
            end else if (!any_beyond(pending_q, step_floor, state_q == S_UP)) begin
              state_d = S_IDLE;
            end
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        S_DOOR: begin
`ifdef DOOR_REOPEN_EN
          if (|(new_raw & here)) begin
            timer_d = '0;
          end else
`endif
          if (timer_q == DOOR_LAST) begin
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A new request overrides a same-cycle clear; the DOOR-floor case is already masked out of new_req.
    pending_d = (pending_q & ~clr) | new_req;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

  assign floor   = floor_q;
  assign state   = state_q;
  assign dir_up  = dir_q;
  assign pending = pending_q;

endmodule
